// File: rtl/udp_status_reporter.sv
// udp_status_reporter: builds 4-word status reply packets (magic, seq, frame
// count, error count) on host request or periodic heartbeat and drives the
// liteeth_core udp_sink stream.
module udp_status_reporter #(
  parameter logic [15:0] LOCAL_PORT       = 16'd6000,
  parameter logic [31:0] HB_IP            = 32'hC0A8_0164,
  parameter logic [15:0] HB_PORT          = 16'd6001,
  parameter logic [31:0] HEARTBEAT_CYCLES = 32'd125_000_000,
  parameter logic [31:0] MAGIC            = 32'h4C45_4443
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ip,
  input  logic [15:0] req_port,
  input  logic        frame_done,
  input  logic        pkt_error,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic [3:0]  udp_sink_error
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_next;
  logic        alive;
  logic [31:0] frame_cnt, frame_snap;
  logic [15:0] err_cnt, err_snap;
  logic [15:0] seq, seq_snap;
  logic [31:0] hb_cnt;
  logic        hb_tick, hb_pending, hb_flag;
  logic [1:0]  word_idx;
  logic        accept_req, accept_hb, handshake, final_hs;

  assign udp_sink_src_port = LOCAL_PORT;
  assign udp_sink_length   = 16'd16;
  assign udp_sink_error    = 4'd0;

  assign handshake = udp_sink_valid & udp_sink_ready;
  assign final_hs  = handshake & (word_idx == 2'd3);
  assign udp_sink_last = udp_sink_valid & (word_idx == 2'd3);
  assign hb_tick = (HEARTBEAT_CYCLES != 32'd0) && (hb_cnt == HEARTBEAT_CYCLES - 32'd1);

  // Holds req_ready low until the first clock edge after reset release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) alive <= 1'b0;
    else       alive <= 1'b1;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, handshake outputs and request-over-heartbeat arbitration
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    udp_sink_valid = 1'b0;
    accept_req     = 1'b0;
    accept_hb      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = alive;
        if (alive) begin
          if (req_valid)       accept_req = 1'b1;
          else if (hb_pending) accept_hb  = 1'b1;
        end
        if (accept_req || accept_hb) state_next = SEND;
      end
      SEND: begin
        udp_sink_valid = 1'b1;
        if (final_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Live frame and error counters; errors saturate so overflow is visible
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= 32'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 32'd1;
      if (pkt_error && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  // Heartbeat timer; at most one heartbeat is ever pending
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hb_cnt     <= 32'd0;
      hb_pending <= 1'b0;
    end else begin
      if (hb_tick || (HEARTBEAT_CYCLES == 32'd0)) hb_cnt <= 32'd0;
      else                                        hb_cnt <= hb_cnt + 32'd1;
      if (accept_hb) hb_pending <= 1'b0;
      if (hb_tick)   hb_pending <= 1'b1;
    end
  end

  // Per-packet snapshot, destination latch, word index and sequence number
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_snap          <= 32'd0;
      err_snap            <= 16'd0;
      seq_snap            <= 16'd0;
      seq                 <= 16'd0;
      hb_flag             <= 1'b0;
      word_idx            <= 2'd0;
      udp_sink_ip_address <= 32'd0;
      udp_sink_dst_port   <= 16'd0;
    end else begin
      if (accept_req || accept_hb) begin
        frame_snap          <= frame_cnt;
        err_snap            <= err_cnt;
        seq_snap            <= seq;
        hb_flag             <= accept_hb;
        word_idx            <= 2'd0;
        udp_sink_ip_address <= accept_req ? req_ip : HB_IP;
        udp_sink_dst_port   <= accept_req ? req_port : HB_PORT;
      end else if (handshake) begin
        word_idx <= word_idx + 2'd1;
      end
      if (final_hs) seq <= seq + 16'd1;
    end
  end

  // Payload word selection; bus reads zero outside a packet
  always_comb begin
    udp_sink_data = 32'd0;
    if (udp_sink_valid) begin
      case (word_idx)
        2'd0:    udp_sink_data = MAGIC;
        2'd1:    udp_sink_data = {seq_snap, 16'd4};
        2'd2:    udp_sink_data = frame_snap;
        default: udp_sink_data = {err_snap, 15'd0, hb_flag};
      endcase
    end
  end

endmodule

// File: tb/tb_udp_status_reporter.sv
// Directed testbench for udp_status_reporter: one instance with heartbeats
// disabled for request/counter/reset tests, one with a 100-cycle heartbeat.
module tb_udp_status_reporter;

  localparam logic [31:0] MAGIC = 32'h4C45_4443;
  localparam logic [31:0] HB_IP = 32'hC0A8_0164;

  logic        clock = 1'b0;
  logic        reset;
  logic        sink_ready;
  logic        req_valid, req_valid_h;
  logic [31:0] req_ip, req_ip_h;
  logic [15:0] req_port, req_port_h;
  logic        frame_done, pkt_error;
  logic        zero_h;

  logic        req_ready, valid, last;
  logic [15:0] src_port, dst_port, length;
  logic [31:0] ip_addr, data;
  logic [3:0]  err;

  logic        req_ready_h, valid_h, last_h;
  logic [15:0] src_port_h, dst_port_h, length_h;
  logic [31:0] ip_addr_h, data_h;
  logic [3:0]  err_h;

  logic        sel;
  logic        mon_req_ready, mon_valid, mon_last;
  logic [15:0] mon_src_port, mon_dst_port, mon_length;
  logic [31:0] mon_ip, mon_data;
  logic [3:0]  mon_err;

  int errors = 0;
  int checks = 0;
  int cyc;

  udp_status_reporter #(.HEARTBEAT_CYCLES(32'd0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip), .req_port(req_port),
    .frame_done(frame_done), .pkt_error(pkt_error),
    .udp_sink_valid(valid), .udp_sink_last(last), .udp_sink_ready(sink_ready),
    .udp_sink_src_port(src_port), .udp_sink_dst_port(dst_port),
    .udp_sink_ip_address(ip_addr), .udp_sink_length(length),
    .udp_sink_data(data), .udp_sink_error(err)
  );

  udp_status_reporter #(.HEARTBEAT_CYCLES(32'd100)) dut_hb (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_h), .req_ready(req_ready_h), .req_ip(req_ip_h), .req_port(req_port_h),
    .frame_done(zero_h), .pkt_error(zero_h),
    .udp_sink_valid(valid_h), .udp_sink_last(last_h), .udp_sink_ready(sink_ready),
    .udp_sink_src_port(src_port_h), .udp_sink_dst_port(dst_port_h),
    .udp_sink_ip_address(ip_addr_h), .udp_sink_length(length_h),
    .udp_sink_data(data_h), .udp_sink_error(err_h)
  );

  assign mon_req_ready = sel ? req_ready_h : req_ready;
  assign mon_valid     = sel ? valid_h     : valid;
  assign mon_last      = sel ? last_h      : last;
  assign mon_src_port  = sel ? src_port_h  : src_port;
  assign mon_dst_port  = sel ? dst_port_h  : dst_port;
  assign mon_length    = sel ? length_h    : length;
  assign mon_ip        = sel ? ip_addr_h   : ip_addr;
  assign mon_data      = sel ? data_h      : data;
  assign mon_err       = sel ? err_h       : err;

  // 100 MHz clock
  always #5 clock = ~clock;

  // Clock edges since the last reset release, used to align with heartbeat ticks
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Holds req_valid on the main instance until accepted, returns on the cycle valid should rise
  task automatic applyStimulus(input logic [31:0] ip, input logic [15:0] port);
    int n;
    req_valid = 1'b1;
    req_ip    = ip;
    req_port  = port;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    req_ip    = 32'd0;
    req_port  = 16'd0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!mon_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "/start"}, 32'(mon_valid), 32'd1);
  endtask

  // Walks one packet on the selected instance, checking every beat including stalls
  task automatic checkPacket(input string tag, input logic [31:0] ip, input logic [15:0] port,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input bit toggle, input bit pulse);
    logic [31:0] exp_w [4];
    int idx, n;
    exp_w = '{w0, w1, w2, w3};
    idx = 0;
    n = 0;
    while (idx < 4 && n < 40) begin
      sink_ready = toggle ? (n % 2 == 0) : 1'b1;
      frame_done = pulse && (n == 1);
      checkOutput({tag, "/valid"},    32'(mon_valid), 32'd1);
      checkOutput({tag, "/data"},     mon_data, exp_w[idx]);
      checkOutput({tag, "/last"},     32'(mon_last), 32'(idx == 3));
      checkOutput({tag, "/ip"},       mon_ip, ip);
      checkOutput({tag, "/port"},     32'(mon_dst_port), 32'(port));
      checkOutput({tag, "/src_port"}, 32'(mon_src_port), 32'd6000);
      checkOutput({tag, "/length"},   32'(mon_length), 32'd16);
      checkOutput({tag, "/error"},    32'(mon_err), 32'd0);
      checkOutput({tag, "/req_ready"}, 32'(mon_req_ready), 32'd0);
      if (mon_valid && sink_ready) idx++;
      @(negedge clock);
      n++;
    end
    frame_done = 1'b0;
    sink_ready = 1'b1;
    checkOutput({tag, "/words"},      32'(idx), 32'd4);
    checkOutput({tag, "/valid_drop"}, 32'(mon_valid), 32'd0);
    checkOutput({tag, "/idle_data"},  mon_data, 32'd0);
    checkOutput({tag, "/cycles"},     32'(n), toggle ? 32'd7 : 32'd4);
  endtask

  initial begin
    reset = 1'b1;
    sink_ready = 1'b1;
    req_valid = 1'b0; req_ip = 32'd0; req_port = 16'd0;
    req_valid_h = 1'b0; req_ip_h = 32'd0; req_port_h = 16'd0;
    frame_done = 1'b0; pkt_error = 1'b0; zero_h = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clock);

    checkOutput("rst/valid",     32'(valid), 32'd0);
    checkOutput("rst/last",      32'(last), 32'd0);
    checkOutput("rst/data",      data, 32'd0);
    checkOutput("rst/ip",        ip_addr, 32'd0);
    checkOutput("rst/port",      32'(dst_port), 32'd0);
    checkOutput("rst/req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    checkOutput("rst/ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clock);
    checkOutput("rst/ready_after_edge", 32'(req_ready), 32'd1);

    $display("[TB] heartbeat instance");
    sel = 1'b1;
    waitValid("hb1");
    checkOutput("hb1/cycle", 32'(cyc), 32'd101);
    checkPacket("hb1", HB_IP, 16'd6001, MAGIC, 32'h0000_0004, 32'd0, 32'h0000_0001, 1'b0, 1'b0);
    waitValid("hb2");
    checkOutput("hb2/cycle", 32'(cyc), 32'd201);
    checkPacket("hb2", HB_IP, 16'd6001, MAGIC, 32'h0001_0004, 32'd0, 32'h0000_0001, 1'b0, 1'b0);
    while (cyc < 299) @(negedge clock);
    req_valid_h = 1'b1; req_ip_h = 32'h0A00_0005; req_port_h = 16'h4321;
    @(negedge clock);
    req_valid_h = 1'b0; req_ip_h = 32'd0; req_port_h = 16'd0;
    checkOutput("tick_req/cycle", 32'(cyc), 32'd300);
    checkPacket("tick_req", 32'h0A00_0005, 16'h4321, MAGIC, 32'h0002_0004, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkPacket("hb_after", HB_IP, 16'd6001, MAGIC, 32'h0003_0004, 32'd0, 32'h0000_0001, 1'b0, 1'b0);

    $display("[TB] request instance");
    sel = 1'b0;
    repeat (3) begin
      frame_done = 1'b1;
      @(negedge clock);
      frame_done = 1'b0;
      @(negedge clock);
    end
    applyStimulus(32'h0A00_0002, 16'd1234);
    checkPacket("req1", 32'h0A00_0002, 16'd1234, MAGIC, 32'h0000_0004, 32'd3, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h0A00_0002, 16'd1234);
    checkPacket("req_stall", 32'h0A00_0002, 16'd1234, MAGIC, 32'h0001_0004, 32'd3, 32'd0, 1'b1, 1'b0);
    applyStimulus(32'h0A00_0003, 16'd77);
    checkPacket("snap", 32'h0A00_0003, 16'd77, MAGIC, 32'h0002_0004, 32'd3, 32'd0, 1'b0, 1'b1);
    applyStimulus(32'h0A00_0003, 16'd77);
    checkPacket("snap_next", 32'h0A00_0003, 16'd77, MAGIC, 32'h0003_0004, 32'd4, 32'd0, 1'b0, 1'b0);

    $display("[TB] reset mid-packet");
    applyStimulus(32'h0A00_0009, 16'd555);
    checkOutput("midrst/word0", data, MAGIC);
    @(negedge clock);
    @(negedge clock);
    sink_ready = 1'b0;
    @(negedge clock);
    checkOutput("midrst/word2", data, 32'd4);
    checkOutput("midrst/valid_stall", 32'(valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst/valid_async", 32'(valid), 32'd0);
    checkOutput("midrst/data_async",  data, 32'd0);
    checkOutput("midrst/ip_async",    ip_addr, 32'd0);
    checkOutput("midrst/req_ready",   32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sink_ready = 1'b1;
    @(negedge clock);
    checkOutput("midrst/ready_back", 32'(req_ready), 32'd1);
    applyStimulus(32'h0A00_0009, 16'd555);
    checkPacket("after_rst", 32'h0A00_0009, 16'd555, MAGIC, 32'h0000_0004, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("[TB] error saturation");
    pkt_error = 1'b1;
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    repeat (69999) @(negedge clock);
    pkt_error = 1'b0;
    @(negedge clock);
    applyStimulus(32'h0A00_000A, 16'd4000);
    checkPacket("sat", 32'h0A00_000A, 16'd4000, MAGIC, 32'h0001_0004, 32'd1, 32'hFFFF_0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_status_reporter.md
Name: udp_status_reporter

Overview:
Transmit-side counterpart of the UDP panel writer: builds short status reply packets and drives the liteeth_core udp_sink stream, which the top level currently ties to zero. A packet is sent either on request, targeting the host that issued the request, or on a periodic heartbeat to a fixed host. The payload is a consistent snapshot of the frame and error counters, so host software can confirm link health and detect dropped frames.

Parameters:
LOCAL_PORT, 16'd6000, udp_sink_src_port value for every packet
HB_IP, 32'hC0A8_0164, heartbeat destination IP (192.168.1.100)
HB_PORT, 16'd6001, heartbeat destination UDP port
HEARTBEAT_CYCLES, 32'd125_000_000, clock cycles between heartbeats; 0 disables heartbeats
MAGIC, 32'h4C45_4443, payload word 0 ("LEDC")

Ports:
clock  input  1  system clock, same domain as udp_panel_writer
reset  input  1  asynchronous, active-high
req_valid  input  1  status request strobe
req_ready  output  1  high when a request can be accepted
req_ip  input  32  requester IP; sampled on accept
req_port  input  16  requester UDP port; sampled on accept
frame_done  input  1  one-cycle pulse per completed panel frame
pkt_error  input  1  one-cycle pulse per rejected or erroneous RX packet
udp_sink_valid  output  1  stream valid
udp_sink_last  output  1  final payload word
udp_sink_ready  input  1  stream ready from liteeth_core
udp_sink_src_port  output  16  fixed to LOCAL_PORT
udp_sink_dst_port  output  16  destination port, latched per packet
udp_sink_ip_address  output  32  destination IP, latched per packet
udp_sink_length  output  16  constant 16'd16 (bytes)
udp_sink_data  output  32  payload word
udp_sink_error  output  4  constant 0

Behaviour:
- Reset values (asynchronous): valid=0, last=0, data=0, dst_port=0, ip_address=0, req_ready=0 while reset is asserted. All counters, seq, hb_pending and word index clear to 0; FSM goes to IDLE. req_ready rises the first clock edge after reset deasserts.
- Reset mid-packet: valid drops immediately and the packet is abandoned. No resume after reset.
- Counters:
  - frame_cnt is 32 bits, +1 per frame_done, wraps at 2^32.
  - err_cnt is 16 bits, +1 per pkt_error, saturates at 16'hFFFF.
  - frame_done and pkt_error in the same cycle both count.
  - seq is 16 bits, +1 on the final-word handshake of each packet, wraps.
- Heartbeat timer (HEARTBEAT_CYCLES != 0):
  - Counts 0..HEARTBEAT_CYCLES-1, then sets hb_pending and restarts.
  - A tick while hb_pending is already set is absorbed; heartbeats do not queue beyond one.
- FSM IDLE:
  - req_ready = 1.
  - If req_valid: accept the request (request has priority). Latch req_ip/req_port, set hb_flag=0.
  - Else if hb_pending: accept the heartbeat. Latch HB_IP/HB_PORT, set hb_flag=1, clear hb_pending.
  - On either accept, snapshot frame_cnt, err_cnt and seq in the same cycle, set word index to 0, go to SEND.
  - A heartbeat tick in the same cycle as a request accept leaves hb_pending set; the heartbeat goes out after the request packet.
- FSM SEND:
  - req_ready = 0 and valid = 1, starting the cycle after accept (latency 1).
  - Payload words by index:
    - 0: MAGIC
    - 1: {seq_snap, 16'd4}
    - 2: frame_snap
    - 3: {err_snap, 15'd0, hb_flag}
  - last = 1 only while index == 3.
  - Index advances only on valid & ready.
  - data, last, ip_address and dst_port hold stable while valid & !ready; valid never drops without a handshake.
  - Counter updates during SEND never alter the snapshot.
  - On the index-3 handshake: increment seq, drop valid, return to IDLE.
  - Minimum gap between packets is one IDLE cycle.
- Requests arriving while req_ready=0 are not accepted. The requester holds req_valid until it sees req_ready.

Test Plan:
- HEARTBEAT_CYCLES=0, ready held 1, 3 frame_done pulses, then req_valid with ip=0x0A000002, port=1234 -> valid rises next cycle. Words are 4C454443, 00000004, 00000003, 00000000. last on word 3, ip/port match, length=16, total 4 cycles.
- Same request with ready toggling 1010… -> identical words. Data, last and address stay stable during every stall cycle.
- frame_done pulsed during SEND -> payload word 2 holds the pre-accept value. The next packet reports the incremented count and seq=1 in word 1.
- HEARTBEAT_CYCLES=100, no requests -> packets to HB_IP/HB_PORT every ~100+ cycles with word 3 bit0=1. With req_valid asserted on the tick cycle, the request packet goes first and the heartbeat follows after one IDLE cycle.
- 70000 pkt_error pulses, with 1 frame_done in the same cycle as the first -> err field = FFFF (saturated) and frame_cnt = 1.
- Assert reset during word 2 with ready=0 -> valid goes 0 asynchronously. After release, req_ready=1 and the next packet has seq=0 and zero counters.
